// File: rtl/cache_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm_pkg
//   Shared types and constants for the miss-handling controller of the 2-way
//   set-associative, write-back, LRU cache (32 sets, 4-word lines).
//   Address layout: {tag[31:9], index[8:4], word[3:2], byte[1:0]}.
// -----------------------------------------------------------------------------
package cache_ctrl_fsm_pkg;

    localparam int ADDR_BITS  = 32;
    localparam int SET_NUM    = 32;
    localparam int LINE_WORDS = 4;

    localparam int IDX_BITS  = 5;
    localparam int WORD_BITS = 2;
    localparam int OFF_BITS  = IDX_BITS - 1;                        // word + byte offset bits
    localparam int TAG_BITS  = ADDR_BITS - IDX_BITS - OFF_BITS;     // 23

    // Width code for a full 32-bit word (LW/SW encoding).
    localparam logic [2:0] UBHW_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_PRE_BACK,
        ST_BACK,
        ST_FILL,
        ST_WAIT
    } state_t;

    // Word-aligned byte address of one word inside a cache line.
    function automatic logic [ADDR_BITS-1:0] line_word_addr(
        input logic [TAG_BITS-1:0]  tag,
        input logic [IDX_BITS-1:0]  idx,
        input logic [WORD_BITS-1:0] word
    );
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm_if
//   Bundles the three buses the controller sits between:
//     CPU side   : req_i, we_i, addr_i, u_b_h_w_i, data_i -> data_o, ack_o, stall_o
//     cache side : c_addr_o, c_load_o, c_store_o, c_edit_o, c_invalid_o,
//                  c_ubhw_o, c_din_o -> c_hit_i, c_valid_i, c_dirty_i,
//                  c_tag_i, c_dout_i (registered, one-cycle latency)
//     memory side: mem_cs_o, mem_we_o, mem_addr_o, mem_data_o
//                  -> mem_data_i, mem_ack_i
//   Suffixes are from the controller's point of view.
//   modport master : the controller (drives cache and memory, answers the CPU)
//   modport slave  : the surrounding CPU / cache / memory
// -----------------------------------------------------------------------------
interface cache_ctrl_fsm_if;
    import cache_ctrl_fsm_pkg::*;

    // CPU side
    logic                 req_i;
    logic                 we_i;
    logic [ADDR_BITS-1:0] addr_i;
    logic [2:0]           u_b_h_w_i;
    logic [31:0]          data_i;
    logic [31:0]          data_o;
    logic                 ack_o;
    logic                 stall_o;

    // Cache side
    logic [ADDR_BITS-1:0] c_addr_o;
    logic                 c_load_o;
    logic                 c_store_o;
    logic                 c_edit_o;
    logic                 c_invalid_o;
    logic [2:0]           c_ubhw_o;
    logic [31:0]          c_din_o;
    logic                 c_hit_i;
    logic                 c_valid_i;
    logic                 c_dirty_i;
    logic [TAG_BITS-1:0]  c_tag_i;
    logic [31:0]          c_dout_i;

    // Memory side
    logic                 mem_cs_o;
    logic                 mem_we_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [31:0]          mem_data_o;
    logic [31:0]          mem_data_i;
    logic                 mem_ack_i;

    modport master (
        input  req_i, we_i, addr_i, u_b_h_w_i, data_i,
        output data_o, ack_o, stall_o,
        output c_addr_o, c_load_o, c_store_o, c_edit_o, c_invalid_o, c_ubhw_o, c_din_o,
        input  c_hit_i, c_valid_i, c_dirty_i, c_tag_i, c_dout_i,
        output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        output req_i, we_i, addr_i, u_b_h_w_i, data_i,
        input  data_o, ack_o, stall_o,
        input  c_addr_o, c_load_o, c_store_o, c_edit_o, c_invalid_o, c_ubhw_o, c_din_o,
        output c_hit_i, c_valid_i, c_dirty_i, c_tag_i, c_dout_i,
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
//   Miss-handling controller between the CPU memory stage and {cache, memory}.
//   - After reset, sweeps all 32 sets with c_invalid_o (INIT).
//   - Hit path: IDLE issues the lookup, CHECK acks one cycle later.
//   - Miss path: writes back a dirty LRU victim word by word (PRE_BACK/BACK),
//     refills the line (FILL), bubbles once (WAIT) and lets the still-pending
//     request re-issue from IDLE, where it now hits.
// Ports
//   clk  : clock
//   rst  : asynchronous reset, active-low
//   bus  : cache_ctrl_fsm_if.master (CPU, cache and memory buses)
// -----------------------------------------------------------------------------
module cache_ctrl_fsm
    import cache_ctrl_fsm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cache_ctrl_fsm_if.master bus
);

    state_t                          state_q, state_d;
    logic [WORD_BITS-1:0]            wcnt_q,  wcnt_d;
    logic [IDX_BITS-1:0]             scnt_q,  scnt_d;
    logic [TAG_BITS-1:0]             vtag_q,  vtag_d;
    // Line address {tag, idx} of the access being serviced. Latched so that a
    // miss already in progress completes on the right line even if the CPU
    // withdraws the request and changes addr_i.
    logic [TAG_BITS+IDX_BITS-1:0]    line_q,  line_d;

    logic [TAG_BITS-1:0]             line_tag;
    logic [IDX_BITS-1:0]             line_idx;
    logic                            ack_w;

    assign line_tag = line_q[TAG_BITS+IDX_BITS-1:IDX_BITS];
    assign line_idx = line_q[IDX_BITS-1:0];

    // A hit only completes while the CPU is still asking for it.
    assign ack_w = (state_q == ST_CHECK) && bus.req_i && bus.c_hit_i;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            vtag_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            vtag_q  <= vtag_d;
            line_q  <= line_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        vtag_d  = vtag_q;
        line_d  = line_q;

        case (state_q)
            ST_INIT: begin
                // scnt wraps back to 0 on the last set.
                scnt_d = scnt_q + 1'b1;
                if (scnt_q == IDX_BITS'(SET_NUM - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (bus.req_i) begin
                    line_d  = bus.addr_i[ADDR_BITS-1:OFF_BITS];
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                // A withdrawn request is dropped here, even on a miss.
                if (!bus.req_i || bus.c_hit_i) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = '0;
                    if (bus.c_valid_i && bus.c_dirty_i) begin
                        vtag_d  = bus.c_tag_i;
                        state_d = ST_PRE_BACK;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_PRE_BACK: begin
                state_d = ST_BACK;
            end

            ST_BACK: begin
                if (bus.mem_ack_i) begin
                    if (wcnt_q == WORD_BITS'(LINE_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        state_d = ST_PRE_BACK;
                    end
                end
            end

            ST_FILL: begin
                if (bus.mem_ack_i) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WORD_BITS'(LINE_WORDS - 1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.data_o      = '0;
        bus.ack_o       = 1'b0;
        bus.c_addr_o    = '0;
        bus.c_load_o    = 1'b0;
        bus.c_store_o   = 1'b0;
        bus.c_edit_o    = 1'b0;
        bus.c_invalid_o = 1'b0;
        bus.c_ubhw_o    = '0;
        bus.c_din_o     = '0;
        bus.mem_cs_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;

        case (state_q)
            ST_INIT: begin
                // Held quiet while reset is asserted; sweeps once released.
                bus.c_invalid_o = rst;
                bus.c_addr_o    = line_word_addr('0, scnt_q, '0);
            end

            ST_IDLE: begin
                bus.c_addr_o = bus.addr_i;
                bus.c_ubhw_o = bus.u_b_h_w_i;
                bus.c_din_o  = bus.data_i;
                if (bus.req_i) begin
                    bus.c_load_o = !bus.we_i;
                    bus.c_edit_o = bus.we_i;
                end
            end

            ST_CHECK: begin
                bus.c_addr_o = bus.addr_i;
                bus.c_ubhw_o = bus.u_b_h_w_i;
                bus.ack_o    = ack_w;
                if (ack_w && !bus.we_i) begin
                    bus.data_o = bus.c_dout_i;
                end
            end

            ST_PRE_BACK: begin
                // No control strobe: the cache presents the LRU victim word.
                bus.c_addr_o = line_word_addr(vtag_q, line_idx, wcnt_q);
            end

            ST_BACK: begin
                // Address kept steady so c_dout_i stays valid for the whole
                // memory write, however long mem_ack_i takes.
                bus.c_addr_o   = line_word_addr(vtag_q, line_idx, wcnt_q);
                bus.mem_cs_o   = 1'b1;
                bus.mem_we_o   = 1'b1;
                bus.mem_addr_o = line_word_addr(vtag_q, line_idx, wcnt_q);
                bus.mem_data_o = bus.c_dout_i;
            end

            ST_FILL: begin
                bus.mem_cs_o   = 1'b1;
                bus.mem_addr_o = line_word_addr(line_tag, line_idx, wcnt_q);
                // Refill word is written into the cache in the ack cycle.
                // c_store_o leaves LRU untouched, so all four words hit one way.
                if (bus.mem_ack_i) begin
                    bus.c_store_o = 1'b1;
                    bus.c_addr_o  = line_word_addr(line_tag, line_idx, wcnt_q);
                    bus.c_din_o   = bus.mem_data_i;
                    bus.c_ubhw_o  = UBHW_WORD;
                end
            end

            default: begin
            end
        endcase
    end

    assign bus.stall_o = ((state_q != ST_IDLE) || bus.req_i) && !ack_w;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
//   Directed bench for cache_ctrl_fsm with a behavioural 2-way LRU write-back
//   cache, a 3-cycle-latency memory, and scoreboard queues of expected memory
//   transactions and CPU acknowledges.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;
    import cache_ctrl_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_fsm_if bus();

    cache_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } ack_exp_t;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural cache: 32 sets x 2 ways x 4 words, LRU bit per set
    logic [22:0] ctag [32][2];
    logic        cval [32][2];
    logic        cdir [32][2];
    logic [31:0] cdat [32][2][4];
    logic        clru [32];

    logic [4:0]  m_ix;
    logic [1:0]  m_wd;
    logic [22:0] m_tg;
    logic        m_h0, m_h1, m_v;
    assign m_ix = bus.c_addr_o[8:4];
    assign m_wd = bus.c_addr_o[3:2];
    assign m_tg = bus.c_addr_o[31:9];
    assign m_h0 = cval[m_ix][0] && (ctag[m_ix][0] == m_tg);
    assign m_h1 = cval[m_ix][1] && (ctag[m_ix][1] == m_tg);
    assign m_v  = clru[m_ix];

    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] code, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (code[1:0])
            2'b00:   r[{off, 3'b000} +: 8]     = d[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        bus.c_hit_i   <= 1'b0;
        bus.c_valid_i <= cval[m_ix][m_v];
        bus.c_dirty_i <= cdir[m_ix][m_v];
        bus.c_tag_i   <= ctag[m_ix][m_v];
        bus.c_dout_i  <= cdat[m_ix][m_v][m_wd];
        if (bus.c_invalid_o) begin
            cval[m_ix][0] <= 1'b0;
            cval[m_ix][1] <= 1'b0;
            cdir[m_ix][0] <= 1'b0;
            cdir[m_ix][1] <= 1'b0;
            clru[m_ix]    <= 1'b0;
        end else if ((bus.c_load_o || bus.c_edit_o) && (m_h0 || m_h1)) begin
            bus.c_hit_i  <= 1'b1;
            clru[m_ix]   <= !m_h1;
            bus.c_dout_i <= cdat[m_ix][m_h1][m_wd];
            if (bus.c_edit_o) begin
                cdat[m_ix][m_h1][m_wd] <= st_merge(cdat[m_ix][m_h1][m_wd], bus.c_din_o,
                                                   bus.c_ubhw_o, bus.c_addr_o[1:0]);
                cdir[m_ix][m_h1] <= 1'b1;
            end
        end else if (bus.c_store_o) begin
            cdat[m_ix][m_v][m_wd] <= bus.c_din_o;
            ctag[m_ix][m_v]       <= m_tg;
            cval[m_ix][m_v]       <= 1'b1;
            cdir[m_ix][m_v]       <= 1'b0;
        end
    end

    // ---------------- memory: ack in the 4th cycle of a held request
    logic [31:0] mem_arr [1024];
    logic        mem_wr  [1024];
    logic [1:0]  dly;
    logic [9:0]  m_mi;
    assign m_mi = bus.mem_addr_o[11:2];

    always @(posedge clk) begin
        if (!bus.mem_cs_o || bus.mem_ack_i) begin
            dly           <= 2'd0;
            bus.mem_ack_i <= 1'b0;
        end else if (dly == 2'd2) begin
            bus.mem_ack_i  <= 1'b1;
            bus.mem_data_i <= mem_wr[m_mi] ? mem_arr[m_mi] : mem_init({20'b0, m_mi, 2'b00});
            if (bus.mem_we_o) begin
                mem_arr[m_mi] <= bus.mem_data_o;
                mem_wr[m_mi]  <= 1'b1;
            end
        end else begin
            dly <= dly + 2'd1;
        end
    end

    // ---------------- scoreboard monitors
    always @(negedge clk) begin
        if (rst && bus.mem_cs_o && bus.mem_ack_i) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected_op", 32'(mem_q.size()), 32'd1);
            end else begin
                chk("mem_addr", bus.mem_addr_o, mem_q[0].addr);
                chk("mem_we", 32'(bus.mem_we_o), 32'(mem_q[0].we));
                if (mem_q[0].we) chk("mem_wdata", bus.mem_data_o, mem_q[0].data);
                void'(mem_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus.ack_o) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", 32'(ack_q.size()), 32'd1);
            end else begin
                if (ack_q[0].is_load) chk("load_data", bus.data_o, ack_q[0].data);
                void'(ack_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic exp_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * i), data: 32'h0});
    endtask

    task automatic exp_ack(input logic is_load, input logic [31:0] d);
        ack_q.push_back('{is_load: is_load, data: d});
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] code,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
        logic done;
        @(posedge clk);
        #1;
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr;
        bus.u_b_h_w_i = code; bus.data_i = wdata;
        lat = 0; done = 1'b0; rdata = '0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (i == 0) chk("stall_on_req", 32'(bus.stall_o), 32'd1);
            if (bus.ack_o) begin
                done  = 1'b1;
                rdata = bus.data_o;
                chk("stall_at_ack", 32'(bus.stall_o), 32'd0);
            end else begin
                lat++;
            end
        end
        if (!done) chk("ack_timeout", 32'(bus.ack_o), 32'd1);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic init_sweep();
        logic any_cs;
        any_cs = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("init_invalid", 32'(bus.c_invalid_o), 32'd1);
            chk("init_addr", bus.c_addr_o, 32'(k) << 4);
            any_cs = any_cs | bus.mem_cs_o;
        end
        @(negedge clk);
        chk("init_done_invalid", 32'(bus.c_invalid_o), 32'd0);
        chk("init_done_stall", 32'(bus.stall_o), 32'd0);
        chk("init_no_mem", 32'(any_cs), 32'd0);
    endtask

    // ---------------- directed sequence
    initial begin
        int          lat;
        logic [31:0] rd, w010, wab;
        logic        seen;

        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
        bus.u_b_h_w_i = '0; bus.data_i = '0;
        w010 = mem_init(32'h010);
        wab  = {w010[31:24], 8'hAB, w010[15:0]};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall_o), 32'd1);
        chk("rst_invalid", 32'(bus.c_invalid_o), 32'd0);
        chk("rst_mem_cs", 32'(bus.mem_cs_o), 32'd0);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_c_addr", bus.c_addr_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        init_sweep();

        // cold miss: refill of 0x010..0x01C, then retry hits
        exp_fill(32'h010);
        exp_ack(1'b1, w010);
        access(1'b0, 32'h010, 3'b010, 32'h0, lat, rd);
        chk("cold_miss_latency", 32'(lat), 32'd20);

        exp_ack(1'b1, w010);
        access(1'b0, 32'h010, 3'b010, 32'h0, lat, rd);
        chk("hit_latency", 32'(lat), 32'd1);

        exp_ack(1'b0, 32'h0);
        access(1'b1, 32'h012, 3'b000, 32'h0000_00AB, lat, rd);
        chk("store_hit_latency", 32'(lat), 32'd1);

        exp_ack(1'b1, wab);
        access(1'b0, 32'h010, 3'b010, 32'h0, lat, rd);
        chk("sb_byte", 32'(rd[23:16]), 32'h0000_00AB);

        // second way of set 1
        exp_fill(32'h210);
        exp_ack(1'b1, mem_init(32'h210));
        access(1'b0, 32'h210, 3'b010, 32'h0, lat, rd);
        chk("way2_miss_latency", 32'(lat), 32'd20);

        // evicts dirty 0x010 line, then refills 0x410
        mem_q.push_back('{we: 1'b1, addr: 32'h010, data: wab});
        for (int i = 1; i < 4; i++)
            mem_q.push_back('{we: 1'b1, addr: 32'h010 + 32'(4 * i), data: mem_init(32'h010 + 32'(4 * i))});
        exp_fill(32'h410);
        exp_ack(1'b1, mem_init(32'h410));
        access(1'b0, 32'h410, 3'b010, 32'h0, lat, rd);
        chk("writeback_latency", 32'(lat), 32'd40);

        // 0x210 must have survived in the other way
        exp_ack(1'b1, mem_init(32'h210));
        access(1'b0, 32'h210, 3'b010, 32'h0, lat, rd);
        chk("lru_keep_latency", 32'(lat), 32'd1);
        chk("memq_drained", 32'(mem_q.size()), 32'd0);
        chk("ackq_drained", 32'(ack_q.size()), 32'd0);

        // reset in the middle of a refill
        exp_fill(32'h810);
        @(posedge clk);
        #1;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h810; bus.u_b_h_w_i = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_cs_o && bus.mem_ack_i;
        end
        chk("fill_first_ack_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_abort_mem_cs", 32'(bus.mem_cs_o), 32'd0);
        chk("rst_abort_stall", 32'(bus.stall_o), 32'd1);
        bus.req_i = 1'b0;
        mem_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_hold_invalid", 32'(bus.c_invalid_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        init_sweep();

        exp_fill(32'h410);
        exp_ack(1'b1, mem_init(32'h410));
        access(1'b0, 32'h410, 3'b010, 32'h0, lat, rd);
        chk("refetch_latency", 32'(lat), 32'd20);
        repeat (2) @(negedge clk);
        chk("final_memq_drained", 32'(mem_q.size()), 32'd0);
        chk("final_ackq_drained", 32'(ack_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
